// File: rtl/adder_resp_checker_if.sv
// Vector stream between the stimulus reader (master) and the response checker (slave).
// Carries one operand/result vector per valid/ready transfer.
//   vec_valid/vec_ready : handshake, transfer when both are high on a rising edge
//   vec_last            : final vector of a run
//   cin, a, b           : adder operands
//   s_duv, cout_duv, prop_duv, gen_duv : outputs of the design under verification
interface adder_resp_checker_if #(
  parameter int unsigned n = 128
);
  logic         vec_valid;
  logic         vec_ready;
  logic         vec_last;
  logic         cin;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic [n-1:0] s_duv;
  logic         cout_duv;
  logic         prop_duv;
  logic         gen_duv;

  modport master (
    output vec_valid, vec_last, cin, a, b, s_duv, cout_duv, prop_duv, gen_duv,
    input  vec_ready
  );

  modport slave (
    input  vec_valid, vec_last, cin, a, b, s_duv, cout_duv, prop_duv, gen_duv,
    output vec_ready
  );
endinterface

// File: rtl/adder_resp_checker.sv
// Response checker for the adder test environment. Takes one vector at a time, computes the
// reference sum/carry/propagate/generate in n/chunk cycles, compares against the DUV outputs
// and keeps pass/fail statistics plus an end-of-run verdict.
//
// Parameters:
//   n        : operand width
//   chunk    : bits added per reference cycle (n must be a multiple of chunk)
//   cmp_type : 0 compares s/cout only, 1 also compares prop/gen
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : begins a run (honoured in IDLE and DONE only)
//   vec            : vector stream (slave side)
//   total_cnt      : vectors checked (saturating)
//   err_cnt        : mismatching vectors (saturating)
//   first_err_idx  : total_cnt value at the first mismatch, valid when first_err_vld
//   done, pass     : run complete, and complete with no errors
// Optional feature (macro ADDER_CHK_ERR_CAPTURE_EN):
//   err_a, err_b, err_cin, err_s_duv : operands and DUV sum of the first mismatching vector
module adder_resp_checker #(
  parameter int unsigned n        = 128,
  parameter int unsigned chunk    = 32,
  parameter bit          cmp_type = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  adder_resp_checker_if.slave        vec,
  output logic [31:0]                total_cnt,
  output logic [31:0]                err_cnt,
  output logic [31:0]                first_err_idx,
  output logic                       first_err_vld,
  output logic                       done,
  output logic                       pass
`ifdef ADDER_CHK_ERR_CAPTURE_EN
  ,
  output logic [n-1:0]               err_a,
  output logic [n-1:0]               err_b,
  output logic                       err_cin,
  output logic [n-1:0]               err_s_duv
`endif
);

  localparam int unsigned K  = n / chunk;
  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StAccept = 3'd1;
  localparam logic [2:0] StCalc   = 3'd2;
  localparam logic [2:0] StCmp    = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]    state_q;
  logic [KW-1:0] k_q;

  // Latched vector
  logic [n-1:0]  a_q, b_q, s_duv_q;
  logic          cin_q, cout_duv_q, prop_duv_q, gen_duv_q, last_q;

  // Reference results built up chunk by chunk
  logic [n-1:0]  s_ref_q;
  logic          carry_q;   // carry chain seeded with cin; ends as cout_ref
  logic          gcarry_q;  // carry chain seeded with 0; ends as gen_ref
  logic          prop_q;

  logic [31:0]   total_cnt_q, err_cnt_q, first_err_idx_q;
  logic          first_err_vld_q;

`ifdef ADDER_CHK_ERR_CAPTURE_EN
  logic [n-1:0]  err_a_q, err_b_q, err_s_duv_q;
  logic          err_cin_q;
`endif

  logic [chunk-1:0] a_chunk, b_chunk;
  logic [chunk:0]   sum_ext;
  logic             gen_c;
  logic             mismatch;

  always_comb begin
    a_chunk = a_q[k_q*chunk +: chunk];
    b_chunk = b_q[k_q*chunk +: chunk];
    sum_ext = {1'b0, a_chunk} + {1'b0, b_chunk} + {{chunk{1'b0}}, carry_q};
    // Carry-out of this chunk on the cin=0 chain
    gen_c   = |(({1'b0, a_chunk} + {1'b0, b_chunk} + {{chunk{1'b0}}, gcarry_q}) >> chunk);
    mismatch = (s_ref_q != s_duv_q) || (carry_q != cout_duv_q) ||
               (cmp_type && ((prop_q != prop_duv_q) || (gcarry_q != gen_duv_q)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      k_q             <= '0;
      a_q             <= '0;
      b_q             <= '0;
      s_duv_q         <= '0;
      cin_q           <= 1'b0;
      cout_duv_q      <= 1'b0;
      prop_duv_q      <= 1'b0;
      gen_duv_q       <= 1'b0;
      last_q          <= 1'b0;
      s_ref_q         <= '0;
      carry_q         <= 1'b0;
      gcarry_q        <= 1'b0;
      prop_q          <= 1'b0;
      total_cnt_q     <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      first_err_vld_q <= 1'b0;
`ifdef ADDER_CHK_ERR_CAPTURE_EN
      err_a_q         <= '0;
      err_b_q         <= '0;
      err_s_duv_q     <= '0;
      err_cin_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            total_cnt_q     <= '0;
            err_cnt_q       <= '0;
            first_err_idx_q <= '0;
            first_err_vld_q <= 1'b0;
`ifdef ADDER_CHK_ERR_CAPTURE_EN
            err_a_q         <= '0;
            err_b_q         <= '0;
            err_s_duv_q     <= '0;
            err_cin_q       <= 1'b0;
`endif
            state_q         <= StAccept;
          end
        end
        StAccept: begin
          if (vec.vec_valid) begin
            a_q        <= vec.a;
            b_q        <= vec.b;
            s_duv_q    <= vec.s_duv;
            cin_q      <= vec.cin;
            cout_duv_q <= vec.cout_duv;
            prop_duv_q <= vec.prop_duv;
            gen_duv_q  <= vec.gen_duv;
            last_q     <= vec.vec_last;
            k_q        <= '0;
            carry_q    <= vec.cin;
            gcarry_q   <= 1'b0;
            prop_q     <= 1'b1;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          s_ref_q[k_q*chunk +: chunk] <= sum_ext[chunk-1:0];
          carry_q  <= sum_ext[chunk];
          gcarry_q <= gen_c;
          prop_q   <= prop_q & (&(a_chunk ^ b_chunk));
          if (k_q == KW'(K - 1)) begin
            state_q <= StCmp;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StCmp: begin
          if (total_cnt_q != '1) total_cnt_q <= total_cnt_q + 32'd1;
          if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 32'd1;
            if (!first_err_vld_q) begin
              first_err_idx_q <= total_cnt_q;
              first_err_vld_q <= 1'b1;
`ifdef ADDER_CHK_ERR_CAPTURE_EN
              err_a_q         <= a_q;
              err_b_q         <= b_q;
              err_s_duv_q     <= s_duv_q;
              err_cin_q       <= cin_q;
`endif
            end
          end
          state_q <= last_q ? StDone : StAccept;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vec.vec_ready   = (state_q == StAccept);
  assign total_cnt       = total_cnt_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_idx   = first_err_idx_q;
  assign first_err_vld   = first_err_vld_q;
  assign done            = (state_q == StDone);
  assign pass            = (state_q == StDone) && (err_cnt_q == 32'd0);
`ifdef ADDER_CHK_ERR_CAPTURE_EN
  assign err_a           = err_a_q;
  assign err_b           = err_b_q;
  assign err_cin         = err_cin_q;
  assign err_s_duv       = err_s_duv_q;
`endif

endmodule

// File: tb/tb_adder_resp_checker.sv
// Bench for adder_resp_checker: two instances (full compare and s/cout-only compare) fed the
// same vector stream, checked every cycle against a transaction-level model, plus literal
// expectations for the directed scenarios.
module tb_adder_resp_checker;
  localparam int N  = 128;
  localparam int CH = 32;
  localparam int K  = N / CH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic         d_valid = 1'b0, d_last = 1'b0, d_cin = 1'b0;
  logic [N-1:0] d_a = '0, d_b = '0, d_s = '0;
  logic         d_cout = 1'b0, d_p = 1'b0, d_g = 1'b0;

  adder_resp_checker_if #(.n(N)) if1 ();
  adder_resp_checker_if #(.n(N)) if0 ();

  assign if1.vec_valid = d_valid;  assign if0.vec_valid = d_valid;
  assign if1.vec_last  = d_last;   assign if0.vec_last  = d_last;
  assign if1.cin       = d_cin;    assign if0.cin       = d_cin;
  assign if1.a         = d_a;      assign if0.a         = d_a;
  assign if1.b         = d_b;      assign if0.b         = d_b;
  assign if1.s_duv     = d_s;      assign if0.s_duv     = d_s;
  assign if1.cout_duv  = d_cout;   assign if0.cout_duv  = d_cout;
  assign if1.prop_duv  = d_p;      assign if0.prop_duv  = d_p;
  assign if1.gen_duv   = d_g;      assign if0.gen_duv   = d_g;

  logic [31:0] total1, err1, fidx1, total0, err0, fidx0;
  logic        fvld1, done1, pass1, fvld0, done0, pass0;
`ifdef ADDER_CHK_ERR_CAPTURE_EN
  logic [N-1:0] ea1, eb1, es1, ea0, eb0, es0;
  logic         ec1, ec0;
`endif

  adder_resp_checker #(.n(N), .chunk(CH), .cmp_type(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .vec(if1.slave),
    .total_cnt(total1), .err_cnt(err1), .first_err_idx(fidx1), .first_err_vld(fvld1),
    .done(done1), .pass(pass1)
`ifdef ADDER_CHK_ERR_CAPTURE_EN
    , .err_a(ea1), .err_b(eb1), .err_cin(ec1), .err_s_duv(es1)
`endif
  );

  adder_resp_checker #(.n(N), .chunk(CH), .cmp_type(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .vec(if0.slave),
    .total_cnt(total0), .err_cnt(err0), .first_err_idx(fidx0), .first_err_vld(fvld0),
    .done(done0), .pass(pass0)
`ifdef ADDER_CHK_ERR_CAPTURE_EN
    , .err_a(ea0), .err_b(eb0), .err_cin(ec0), .err_s_duv(es0)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // mode: 0 idle, 1 waiting for a vector, 2 vector in flight, 3 run done
  int          m_mode = 0;
  int          m_lat = 0;
  logic [31:0] m_total = 0, m_err1 = 0, m_err0 = 0, m_fidx1 = 0, m_fidx0 = 0;
  logic        m_fvld1 = 0, m_fvld0 = 0;
  logic        p_mis1 = 0, p_mis0 = 0, p_last = 0;
  logic [N-1:0] p_a = '0, p_b = '0, p_s = '0, m_ea = '0, m_eb = '0, m_es = '0;
  logic        p_cin = 0, m_ec = 0;

  always @(posedge clk) begin
    logic [N:0] full;
    logic       pr, gr;
    cyc++;
    if (rst) begin
      m_mode = 0; m_lat = 0; m_total = 0; m_err1 = 0; m_err0 = 0;
      m_fidx1 = 0; m_fidx0 = 0; m_fvld1 = 0; m_fvld0 = 0;
      m_ea = '0; m_eb = '0; m_es = '0; m_ec = 0;
    end else begin
      case (m_mode)
        0, 3: if (start) begin
          m_mode = 1; m_total = 0; m_err1 = 0; m_err0 = 0;
          m_fidx1 = 0; m_fidx0 = 0; m_fvld1 = 0; m_fvld0 = 0;
          m_ea = '0; m_eb = '0; m_es = '0; m_ec = 0;
        end
        1: if (d_valid) begin
          full = {1'b0, d_a} + {1'b0, d_b} + {{N{1'b0}}, d_cin};
          pr = &(d_a ^ d_b);
          gr = |(({1'b0, d_a} + {1'b0, d_b}) >> N);
          p_mis0 = (full[N-1:0] != d_s) || (full[N] != d_cout);
          p_mis1 = p_mis0 || (pr != d_p) || (gr != d_g);
          p_last = d_last; p_a = d_a; p_b = d_b; p_s = d_s; p_cin = d_cin;
          m_lat = K + 1; m_mode = 2;
        end
        2: begin
          m_lat--;
          if (m_lat == 0) begin
            if (p_mis1) begin
              if (m_err1 != 32'hFFFFFFFF) m_err1++;
              if (!m_fvld1) begin
                m_fidx1 = m_total; m_fvld1 = 1;
                m_ea = p_a; m_eb = p_b; m_es = p_s; m_ec = p_cin;
              end
            end
            if (p_mis0) begin
              if (m_err0 != 32'hFFFFFFFF) m_err0++;
              if (!m_fvld0) begin m_fidx0 = m_total; m_fvld0 = 1; end
            end
            if (m_total != 32'hFFFFFFFF) m_total++;
            m_mode = p_last ? 3 : 1;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("ready1", if1.vec_ready, m_mode == 1);
      chk("ready0", if0.vec_ready, m_mode == 1);
      chk("total1", total1, m_total);
      chk("total0", total0, m_total);
      chk("err1", err1, m_err1);
      chk("err0", err0, m_err0);
      chk("fidx1", fidx1, m_fidx1);
      chk("fvld1", fvld1, m_fvld1);
      chk("fidx0", fidx0, m_fidx0);
      chk("fvld0", fvld0, m_fvld0);
      chk("done1", done1, m_mode == 3);
      chk("done0", done0, m_mode == 3);
      chk("pass1", pass1, (m_mode == 3) && (m_err1 == 0));
      chk("pass0", pass0, (m_mode == 3) && (m_err0 == 0));
`ifdef ADDER_CHK_ERR_CAPTURE_EN
      chk("err_a1", ea1, m_ea);
      chk("err_b1", eb1, m_eb);
      chk("err_s1", es1, m_es);
      chk("err_cin1", ec1, m_ec);
`endif
    end
  end

  // ---------------- stimulus ----------------
  time acc_time;

  // kind: 0 correct, 1 flip s[0], 2 flip cout, 3 flip prop, 4 flip gen
  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tcin,
                      input int kind, input logic tlast);
    logic [N:0] full;
    int bound;
    full = {1'b0, ta} + {1'b0, tb_} + {{N{1'b0}}, tcin};
    d_a = ta; d_b = tb_; d_cin = tcin; d_last = tlast;
    d_s = full[N-1:0]; d_cout = full[N];
    d_p = &(ta ^ tb_);
    d_g = |(({1'b0, ta} + {1'b0, tb_}) >> N);
    case (kind)
      1: d_s[0] = ~d_s[0];
      2: d_cout = ~d_cout;
      3: d_p = ~d_p;
      4: d_g = ~d_g;
      default: ;
    endcase
    d_valid = 1'b1;
    bound = 0;
    while (!if1.vec_ready && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready got 0 expected 1 within 100 cycles");
      d_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_time = $time;
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result();
    repeat (K + 1) @(negedge clk);
  endtask

  function automatic logic [N-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [N-1:0] ones, ra, rb, a2, b2;
    time prev;
    ones = '1;
    repeat (3) @(negedge clk);
    chk("rst_total", total1, 0);
    chk("rst_ready", if1.vec_ready, 0);
    chk("rst_done", done1, 0);
    rst = 1'b0;
    @(negedge clk);

    // three correct vectors
    pulse_start();
    send(128'd1, 128'd2, 1'b0, 0, 1'b0);
    send(128'd5, 128'd6, 1'b1, 0, 1'b0);
    send(128'd100, 128'd200, 1'b0, 0, 1'b1);
    wait_result();
    chk("t1_total", total1, 3);
    chk("t1_err", err1, 0);
    chk("t1_done", done1, 1);
    chk("t1_pass", pass1, 1);

    // all-ones + 0 + 1, then same with bad cout
    pulse_start();
    send(ones, '0, 1'b1, 0, 1'b0);
    wait_result();
    chk("t2_err_a", err1, 0);
    send(ones, '0, 1'b1, 2, 1'b1);
    wait_result();
    chk("t2_err_b", err1, 1);
    chk("t2_pass", pass1, 0);

    // five vectors, 2nd and 4th wrong
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      ra = rnd(); rb = rnd();
      if (i == 1) begin a2 = ra; b2 = rb; end
      send(ra, rb, i[0], (i == 1 || i == 3) ? 1 : 0, i == 4);
    end
    wait_result();
    chk("t3_err", err1, 2);
    chk("t3_fidx", fidx1, 1);
    chk("t3_pass", pass1, 0);
`ifdef ADDER_CHK_ERR_CAPTURE_EN
    chk("t3_err_a", ea1, a2);
    chk("t3_err_b", eb1, b2);
`endif

    // only gen wrong: s/cout-only checker must pass
    pulse_start();
    send(128'd3, 128'd1, 1'b0, 4, 1'b1);
    wait_result();
    chk("t4_err_type0", err0, 0);
    chk("t4_err_type1", err1, 1);

    // valid held high: accepts every K+2 cycles
    pulse_start();
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      send(rnd(), rnd(), 1'(i), 0, i == 5);
      if (i > 0) chk("t5_spacing", 128'(acc_time - prev), 60);
      prev = acc_time;
    end
    wait_result();
    chk("t5_total", total1, 6);

    // reset during the second CALC cycle
    pulse_start();
    send(rnd(), rnd(), 1'b0, 1, 1'b0);
    send(rnd(), rnd(), 1'b0, 0, 1'b0);
    wait_result();
    send(rnd(), rnd(), 1'b1, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_total", total1, 0);
    chk("t6_err", err1, 0);
    chk("t6_fvld", fvld1, 0);
    chk("t6_ready", if1.vec_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    send(rnd(), rnd(), 1'b0, 0, 1'b1);
    wait_result();
    chk("t6_total_after", total1, 1);

    // random stream with an ignored start pulse mid-run
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      ra = rnd();
      rb = ($urandom_range(0, 3) == 0) ? ~ra : rnd();
      if (i == 5) pulse_start();
      send(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 7), i == 19);
    end
    wait_result();
    chk("t7_total", total1, 20);
    chk("t7_done", done1, 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_resp_checker.md
# adder_resp_checker

Synthesizable response checker for the adder test environment: accepts one operand/result vector at a time from the stimulus side, computes the reference sum, carry-out, propagate and generate internally over several cycles, and compares them against the design-under-verification outputs. It keeps pass and fail counts and reports an end-of-run verdict. It is the consuming end of the vector stream that the stimulus reader produces, and it lets adder checking run on an FPGA without file I/O.

## Interface
Parameters:
- `n`, 128: operand width.
- `chunk`, 32: bits added per reference-calculation cycle. `n % chunk == 0` is required.
- `type`, 1: 0 compares `s` and `cout` only (csa/cra/a1csa); 1 also compares `prop` and `gen` (cla/a1csah).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a run. It is honoured in IDLE and DONE only.
- `vec_valid` in 1: the vector on the input ports is valid.
- `vec_ready` out 1: the checker can take a vector.
- `vec_last` in 1: qualifies the final vector of a run.
- `cin` in 1, `a` in n, `b` in n: operands.
- `s_duv` in n, `cout_duv` in 1, `prop_duv` in 1, `gen_duv` in 1: outputs of the design under verification.
- `total_cnt` out 32: number of vectors checked.
- `err_cnt` out 32: number of mismatching vectors.
- `first_err_idx` out 32: value of `total_cnt` at the first mismatch.
- `first_err_vld` out 1: `first_err_idx` holds a valid value.
- `done` out 1: the run is complete.
- `pass` out 1: `done` is set and `err_cnt == 0`.

## Operation
- Reset value of every output is 0. The state machine resets to IDLE.
- The checker has four states: IDLE, ACCEPT, CALC and CMP, plus DONE.
- IDLE:
  - `vec_ready` = 0.
  - On `start`: clear all counters, `first_err_vld` and the sticky flags, then go to ACCEPT.
- ACCEPT:
  - `vec_ready` = 1.
  - On `vec_valid & vec_ready`, register `cin`, `a`, `b`, `s_duv`, `cout_duv`, `prop_duv`, `gen_duv` and `vec_last`, then go to CALC.
- CALC:
  - Runs for K = n/chunk cycles. Cycle k adds bits `[k*chunk +: chunk]` with the carry from cycle k-1; cycle 0 uses the registered `cin`.
  - `prop_ref` = AND over all bits of (a^b).
  - `gen_ref` = carry-out of a+b with cin forced to 0, computed in the same chunked pass.
  - After cycle K-1, go to CMP.
- CMP: one cycle.
  - A mismatch is `s_ref != s_duv` OR `cout_ref != cout_duv` OR, when `type == 1`, (`prop_ref != prop_duv` OR `gen_ref != gen_duv`).
  - `total_cnt` increments.
  - On a mismatch, `err_cnt` increments. If `first_err_vld == 0`, load `first_err_idx` with the pre-increment `total_cnt` and set `first_err_vld`.
  - Next state is DONE if the latched `vec_last` is 1, otherwise ACCEPT.
- DONE:
  - `done` = 1 and `pass` = (`err_cnt == 0`).
  - `vec_ready` = 0.
  - `start` returns to ACCEPT with everything cleared.
- Both counters saturate at 32'hFFFFFFFF and never wrap.
- Boundary conditions:
  - `start` in ACCEPT, CALC or CMP is ignored.
  - `rst` at any point, including mid-CALC, returns immediately to IDLE with all outputs 0. A vector that was in flight is dropped and not counted.
  - `vec_valid` without `vec_ready` is held off; no vector is lost, and the source must hold the vector stable.

## Timing
- The handshake follows the valid/ready rule: a transfer happens only on a clock edge where `vec_valid & vec_ready` are both 1.
- `vec_ready` falls the cycle after an accept.
- Latency: accept on edge t, CALC on edges t+1..t+K, CMP on edge t+K+1. Updated counters are visible after edge t+K+1.
- `vec_ready` is 1 again after edge t+K+1.
- Throughput: one vector every K+2 cycles, which is 6 cycles at the default parameters.
- `done` and `pass` assert after the CMP edge of the last vector.

## Configuration
- `ADDER_CHK_ERR_CAPTURE_EN` defined:
  - Adds the outputs `err_a` (n), `err_b` (n), `err_cin` (1) and `err_s_duv` (n).
  - These are loaded alongside `first_err_idx` on the first mismatch and otherwise hold.
  - They reset to 0 and clear on `start`.
- `ADDER_CHK_ERR_CAPTURE_EN` undefined: these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Reset, `start`, then 3 correct vectors (a=1, b=2, cin=0, s_duv=3; etc.) with `vec_last` on the third -> `total_cnt`=3, `err_cnt`=0, `done`=1, `pass`=1.
- a=all-ones, b=0, cin=1, s_duv=0, cout_duv=1, prop_duv=1, gen_duv=0 -> no error. The same vector with cout_duv=0 -> `err_cnt`=1.
- Five vectors with mismatches at the 2nd and 4th -> `err_cnt`=2, `first_err_idx`=1, `pass`=0. With `ADDER_CHK_ERR_CAPTURE_EN`, `err_a`/`err_b` equal the 2nd vector.
- `type`=0 with only `gen_duv` wrong -> `err_cnt`=0. `type`=1 with the same vector -> `err_cnt`=1.
- Hold `vec_valid`=1 continuously -> accepts are spaced exactly 6 cycles apart, and `vec_ready` is low for 5 of every 6 cycles.
- Assert `rst` during the 2nd CALC cycle -> next cycle all outputs are 0 and the state is IDLE. A fresh `start` plus 1 vector -> `total_cnt`=1.
